// File: rtl/shot_scheduler.sv
// Shot deploy scheduler: frame-paced IDLE/DEPLOY/COOLDOWN FSM, high-damage timer,
// and an optional ammo counter compiled in with `define SHOT_AMMO_EN.
module shot_scheduler #(
  parameter int unsigned NUM_OF_SHOTS    = 8,
  parameter int unsigned COOLDOWN_FRAMES = 10,
  parameter int unsigned HD_FRAMES       = 300,
  parameter int unsigned AMMO_MAX        = 20
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    fire,
  input  logic [NUM_OF_SHOTS-1:0] shots_active,
  input  logic                    powerup,
  input  logic                    ammo_refill,
  output logic [NUM_OF_SHOTS-1:0] deploy_shot,
  output logic                    high_damage,
  output logic [7:0]              ammo_count,
  output logic                    busy
);

  localparam int unsigned CD_W   = 8;
  localparam int unsigned HD_W   = 10;
  localparam int unsigned AMMO_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEPLOY   = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CD_W-1:0]         cd_q, cd_d;
  logic [HD_W-1:0]         hd_q, hd_d;
  logic [NUM_OF_SHOTS-1:0] deploy_q, deploy_d;
  logic                    busy_q;
  logic                    hd_flag_q;
  logic [NUM_OF_SHOTS-1:0] free_c;
  logic [NUM_OF_SHOTS-1:0] lowest_free_c;
  logic                    ammo_avail_c;

  // Isolate the lowest set bit of the free mask (two's-complement trick).
  assign free_c        = ~shots_active;
  assign lowest_free_c = free_c & (~free_c + NUM_OF_SHOTS'(1));

  // Next-state and deploy strobe.
  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    deploy_d = '0;
    case (state_q)
      IDLE: begin
        if (startOfFrame && fire && (|free_c) && ammo_avail_c) begin
          state_d  = DEPLOY;
          deploy_d = lowest_free_c;
        end
      end
      DEPLOY: begin
        state_d = COOLDOWN;
        cd_d    = CD_W'(COOLDOWN_FRAMES);
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (cd_q <= CD_W'(1)) begin
            state_d = IDLE;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - CD_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cd_d    = '0;
      end
    endcase
  end

  // High-damage timer; a powerup reloads and wins over a coincident frame tick.
  always_comb begin
    hd_d = hd_q;
    if (powerup) begin
      hd_d = HD_W'(HD_FRAMES);
    end else if (startOfFrame && (hd_q != '0)) begin
      hd_d = hd_q - HD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      hd_q      <= '0;
      deploy_q  <= '0;
      busy_q    <= 1'b0;
      hd_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      hd_q      <= hd_d;
      deploy_q  <= deploy_d;
      busy_q    <= (state_d != IDLE);
      hd_flag_q <= (hd_d != '0);
    end
  end

  assign deploy_shot = deploy_q;
  assign busy        = busy_q;
  assign high_damage = hd_flag_q;

`ifdef SHOT_AMMO_EN
  logic [AMMO_W-1:0] ammo_q, ammo_d;

  // Refill overrides the deploy decrement; never decrement below zero.
  always_comb begin
    ammo_d = ammo_q;
    if (ammo_refill) begin
      ammo_d = AMMO_W'(AMMO_MAX);
    end else if ((state_q == DEPLOY) && (ammo_q != '0)) begin
      ammo_d = ammo_q - AMMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ammo_q <= AMMO_W'(AMMO_MAX);
    end else begin
      ammo_q <= ammo_d;
    end
  end

  assign ammo_avail_c = (ammo_q != '0);
  assign ammo_count   = ammo_q;
`else
  logic unused_ammo_refill;

  assign unused_ammo_refill = ammo_refill;
  assign ammo_avail_c       = 1'b1;
  assign ammo_count         = AMMO_W'(AMMO_MAX);
`endif

endmodule

// File: tb/tb_shot_scheduler.sv
// Self-checking bench for shot_scheduler: directed scenarios plus a randomized
// run against a frame-level reference model.
module tb_shot_scheduler;

  localparam int unsigned N  = 8;
  localparam int unsigned CD = 10;
  localparam int unsigned HD = 300;
`ifdef SHOT_AMMO_EN
  localparam int unsigned AMAX = 2;
`else
  localparam int unsigned AMAX = 20;
`endif

  logic         clk;
  logic         resetN;
  logic         sof;
  logic         fire;
  logic [N-1:0] shots;
  logic         powerup;
  logic         refill;
  logic [N-1:0] deploy;
  logic         hd;
  logic [7:0]   ammo;
  logic         busy;

  int checks = 0;
  int errors = 0;

  shot_scheduler #(
    .NUM_OF_SHOTS(N), .COOLDOWN_FRAMES(CD), .HD_FRAMES(HD), .AMMO_MAX(AMAX)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .fire(fire),
    .shots_active(shots), .powerup(powerup), .ammo_refill(refill),
    .deploy_shot(deploy), .high_damage(hd), .ammo_count(ammo), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetN = 1'b0; sof = 1'b0; fire = 1'b0; shots = '0; powerup = 1'b0; refill = 1'b0;
    step(); step();
    resetN = 1'b1;
    step();
  endtask

  task automatic test_reset();
    resetN = 1'b1; sof = 1'b0; fire = 1'b0; shots = '0; powerup = 1'b0; refill = 1'b0;
    #1 resetN = 1'b0;
    #2;
    checks++; if (deploy !== '0) begin errors++; $display("FAIL reset_deploy got %h exp 0", deploy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (hd !== 1'b0) begin errors++; $display("FAIL reset_hd got %b exp 0", hd); end
    checks++; if (ammo !== 8'(AMAX)) begin errors++; $display("FAIL reset_ammo got %0d exp %0d", ammo, AMAX); end
    step(); step();
    resetN = 1'b1;
    step();
  endtask

  task automatic test_single_deploy();
    apply_reset();
    shots = 8'b0000_0101; fire = 1'b1; sof = 1'b1;
    step();
    sof = 1'b0; fire = 1'b0;
    checks++; if (deploy !== 8'b0000_0010) begin errors++; $display("FAIL single_deploy got %b exp 00000010", deploy); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_deploy got %b exp 1", busy); end
    step();
    checks++; if (deploy !== '0) begin errors++; $display("FAIL single_one_clk got %b exp 0", deploy); end
    for (int k = 1; k <= int'(CD); k++) begin
      sof = 1'b1; step(); sof = 1'b0; step();
      checks++;
      if (busy !== (k < int'(CD))) begin
        errors++; $display("FAIL single_busy_frame%0d got %b exp %b", k, busy, (k < int'(CD)));
      end
    end
  endtask

  task automatic test_spacing();
    int next_ok;
    int left;
    logic [N-1:0] exp_d;
    apply_reset();
    fire = 1'b1; shots = '0; next_ok = 0; left = int'(AMAX);
    for (int f = 0; f < 30; f++) begin
      sof = 1'b1; step(); sof = 1'b0;
      exp_d = '0;
      if (f >= next_ok && left > 0) begin
        exp_d[0] = 1'b1; next_ok = f + int'(CD) + 1;
`ifdef SHOT_AMMO_EN
        left--;
`endif
      end
      checks++;
      if (deploy !== exp_d) begin errors++; $display("FAIL spacing_frame%0d got %b exp %b", f, deploy, exp_d); end
      step(); step();
    end
    fire = 1'b0;
  endtask

  task automatic test_all_busy();
    apply_reset();
    shots = '1; fire = 1'b1;
    for (int f = 0; f < 5; f++) begin
      sof = 1'b1; step(); sof = 1'b0;
      checks++; if (deploy !== '0) begin errors++; $display("FAIL allbusy_deploy f%0d got %b exp 0", f, deploy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL allbusy_busy f%0d got %b exp 0", f, busy); end
      step();
    end
    fire = 1'b0; shots = '0;
  endtask

  task automatic test_high_damage();
    int frames;
    int bad;
    apply_reset();
    powerup = 1'b1; step(); powerup = 1'b0;
    checks++; if (hd !== 1'b1) begin errors++; $display("FAIL hd_on got %b exp 1", hd); end
    step();
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      sof = 1'b1; powerup = (i == 149); step(); sof = 1'b0; powerup = 1'b0;
      if (hd !== 1'b1) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hd_first_period low_frames %0d exp 0", bad); end
    frames = 150;
    while (hd === 1'b1 && frames < 1000) begin
      sof = 1'b1; step(); sof = 1'b0; frames++; step();
    end
    checks++;
    if (frames != 150 + int'(HD)) begin
      errors++; $display("FAIL hd_total_frames got %0d exp %0d", frames, 150 + int'(HD));
    end
  endtask

  task automatic test_ammo();
`ifdef SHOT_AMMO_EN
    logic [N-1:0] exp_d;
    int left;
    apply_reset();
    fire = 1'b1; shots = '0; left = int'(AMAX);
    for (int f = 0; f < 25; f++) begin
      sof = 1'b1; step(); sof = 1'b0;
      exp_d = '0;
      if ((f % (int'(CD) + 1)) == 0 && left > 0) begin exp_d[0] = 1'b1; left--; end
      checks++;
      if (deploy !== exp_d) begin errors++; $display("FAIL ammo_frame%0d got %b exp %b", f, deploy, exp_d); end
      step(); step();
    end
    checks++; if (ammo !== 8'd0) begin errors++; $display("FAIL ammo_empty got %0d exp 0", ammo); end
    refill = 1'b1; step(); refill = 1'b0;
    checks++; if (ammo !== 8'(AMAX)) begin errors++; $display("FAIL ammo_refill got %0d exp %0d", ammo, AMAX); end
    sof = 1'b1; step(); sof = 1'b0;
    checks++; if (deploy !== 8'h01) begin errors++; $display("FAIL ammo_after_refill got %b exp 1", deploy); end
    refill = 1'b1; step(); refill = 1'b0;
    checks++; if (ammo !== 8'(AMAX)) begin errors++; $display("FAIL ammo_refill_in_deploy got %0d exp %0d", ammo, AMAX); end
    fire = 1'b0;
`else
    apply_reset();
    refill = 1'b1; step(); refill = 1'b0;
    checks++; if (ammo !== 8'(AMAX)) begin errors++; $display("FAIL ammo_const_refill got %0d exp %0d", ammo, AMAX); end
    fire = 1'b1; sof = 1'b1; step(); sof = 1'b0; fire = 1'b0;
    checks++; if (deploy !== 8'h01) begin errors++; $display("FAIL ammo_free_deploy got %b exp 1", deploy); end
    step();
    checks++; if (ammo !== 8'(AMAX)) begin errors++; $display("FAIL ammo_const_deploy got %0d exp %0d", ammo, AMAX); end
`endif
  endtask

  task automatic test_reset_abort();
    apply_reset();
    powerup = 1'b1; step(); powerup = 1'b0;
    fire = 1'b1; shots = '0; sof = 1'b1; step(); sof = 1'b0; fire = 1'b0;
    checks++; if (deploy !== 8'h01) begin errors++; $display("FAIL abort_pre_deploy got %b exp 1", deploy); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (deploy !== '0) begin errors++; $display("FAIL abort_deploy_async got %b exp 0", deploy); end
    checks++; if (hd !== 1'b0) begin errors++; $display("FAIL abort_hd_async got %b exp 0", hd); end
    step(); step();
    resetN = 1'b1;
    checks++; if (deploy !== '0) begin errors++; $display("FAIL abort_no_pulse got %b exp 0", deploy); end
    fire = 1'b1; sof = 1'b1; step(); sof = 1'b0; fire = 1'b0;
    step();
    for (int f = 0; f < 3; f++) begin sof = 1'b1; step(); sof = 1'b0; step(); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_cooldown got %b exp 1", busy); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_async got %b exp 0", busy); end
    checks++; if (ammo !== 8'(AMAX)) begin errors++; $display("FAIL abort_ammo got %0d exp %0d", ammo, AMAX); end
    step();
    resetN = 1'b1;
    step();
    fire = 1'b1; sof = 1'b1; step(); sof = 1'b0; fire = 1'b0;
    checks++; if (deploy !== 8'h01) begin errors++; $display("FAIL abort_redeploy got %b exp 1", deploy); end
    step();
    checks++; if (deploy !== '0) begin errors++; $display("FAIL abort_redeploy_one_clk got %b exp 0", deploy); end
  endtask

  // Frame-level model: deploy eligibility follows from frame index of the last deploy.
  task automatic test_random();
    bit           has_dep;
    int           last;
    int           m_ammo;
    int           m_hd;
    int           gap;
    bit           eligible;
    bit           pu;
    bit           rf;
    logic [N-1:0] exp_d;
    apply_reset();
    has_dep = 1'b0; last = 0; m_ammo = int'(AMAX); m_hd = 0;
    for (int fr = 0; fr < 400; fr++) begin
      shots   = (($urandom % 5) == 0) ? '1 : (N'($urandom) | N'($urandom));
      fire    = (($urandom % 4) != 0);
      powerup = (($urandom % 40) == 0);
      eligible = fire && (shots != '1) && (m_ammo > 0) && (!has_dep || fr >= last + int'(CD) + 1);
      exp_d = '0;
      if (eligible) begin
        for (int i = N - 1; i >= 0; i--) if (!shots[i]) exp_d = N'(1) << i;
        has_dep = 1'b1; last = fr;
`ifdef SHOT_AMMO_EN
        m_ammo--;
`endif
      end
      if (powerup) m_hd = int'(HD);
      else if (m_hd > 0) m_hd--;
      sof = 1'b1; step(); sof = 1'b0; powerup = 1'b0;
      checks++; if (deploy !== exp_d) begin errors++; $display("FAIL rand_deploy fr%0d got %b exp %b", fr, deploy, exp_d); end
      checks++;
      if (busy !== (has_dep && (fr - last) < int'(CD))) begin
        errors++; $display("FAIL rand_busy fr%0d got %b exp %b", fr, busy, (has_dep && (fr - last) < int'(CD)));
      end
      checks++; if (hd !== (m_hd != 0)) begin errors++; $display("FAIL rand_hd fr%0d got %b exp %b", fr, hd, (m_hd != 0)); end
      gap = 1 + int'($urandom % 3);
      for (int g = 1; g <= gap; g++) begin
        rf = (g == 1) && (($urandom % 8) == 0);
        pu = (($urandom % 60) == 0);
        refill = rf; powerup = pu;
        step();
        refill = 1'b0; powerup = 1'b0;
`ifdef SHOT_AMMO_EN
        if (rf) m_ammo = int'(AMAX);
`endif
        if (pu) m_hd = int'(HD);
        checks++; if (deploy !== '0) begin errors++; $display("FAIL rand_gap_deploy fr%0d got %b exp 0", fr, deploy); end
        checks++; if (ammo !== 8'(m_ammo)) begin errors++; $display("FAIL rand_ammo fr%0d got %0d exp %0d", fr, ammo, m_ammo); end
        checks++; if (hd !== (m_hd != 0)) begin errors++; $display("FAIL rand_gap_hd fr%0d got %b exp %b", fr, hd, (m_hd != 0)); end
      end
    end
    fire = 1'b0; shots = '0;
  endtask

  initial begin
    test_reset();
    test_single_deploy();
    test_spacing();
    test_all_busy();
    test_high_damage();
    test_ammo();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
